// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller.
//   state_t       : controller FSM state (IDLE/RUN/DONE), 2-bit encoded
//   DEFAULT_WIDTH : default operand/result width in bits
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders and an OR gate.
//   a, b : operand bits
//   cin  : carry in
//   sum  : sum bit
//   cout : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic hs1, hc1, hc2;

  // first half adder: a + b
  assign hs1  = a ^ b;
  assign hc1  = a & b;
  // second half adder: partial sum + cin
  assign sum  = hs1 ^ cin;
  assign hc2  = hs1 & cin;
  assign cout = hc1 | hc2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor with valid/ready handshakes on both sides.
// One operand bit pair is processed per cycle, LSB first, through a single
// full adder; an operation takes WIDTH cycles in RUN.
//   clk, reset_n          : clock, async active-low reset
//   start_valid/ready     : operation request handshake (ready only in IDLE)
//   op_a, op_b, sub       : operands and mode (0 = a+b, 1 = a-b)
//   result                : sum/difference, held while done_valid
//   carry_out             : final carry (for sub, 1 = no borrow)
//   overflow              : two's-complement signed overflow
//   done_valid/ready      : result handshake (valid only in DONE)
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             c_q, cout_q, ovf_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_sum, fa_cout;
  logic             last;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // final RUN cycle is the one processing bit WIDTH-1
  assign last = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: subtraction is a + ~b + 1, the +1 entering as the initial carry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q   <= op_a;
            b_q   <= sub ? ~op_b : op_b;
            c_q   <= sub;
            cnt_q <= '0;
          end
        end
        RUN: begin
          res_q <= {fa_sum, res_q[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= fa_cout;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            cout_q <= fa_cout;
            // carry into MSB xor carry out of MSB
            ovf_q  <= c_q ^ fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n, start_valid, sub, done_ready;
  logic [W-1:0] op_a, op_b, result;
  logic         start_ready, carry_out, overflow, done_valid;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .result      (result),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain W+1-bit arithmetic, returns {overflow, carry, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ov;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (W+1)'(s);
    ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {ov, full[W], full[W-1:0]};
  endfunction

  // Runs one operation; lat counts edges from the accepting edge (inclusive)
  // to the edge after which done_valid is high.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int hold, output logic [W-1:0] r, output logic c,
                        output logic o, output int lat);
    op_a = a; op_b = b; sub = s; start_valid = 1'b1;
    tick();
    lat = 1;
    // operands are only sampled on the accepting edge: scramble them now
    start_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; sub = 1'($urandom_range(0, 1));
    while (!done_valid && lat < 200) begin
      tick();
      lat++;
    end
    r = result; c = carry_out; o = overflow;
    repeat (hold) tick();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] er, input logic ec,
                          input logic eo);
    logic [W-1:0] r;
    logic c, o;
    int lat;
    check({tag, ".start_ready"}, 64'(start_ready), 64'd1);
    run_op(a, b, s, 2, r, c, o, lat);
    check({tag, ".latency"}, 64'(lat), 64'd33);
    check({tag, ".result"}, 64'(r), 64'(er));
    check({tag, ".carry"}, 64'(c), 64'(ec));
    check({tag, ".ovf"}, 64'(o), 64'(eo));
  endtask

  initial begin
    logic [W-1:0] r;
    logic c, o, seen;
    logic [W+1:0] exp;
    int lat;

    reset_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0; sub = 1'b0;
    op_a = '0; op_b = '0;
    #2;
    check("rst.start_ready", 64'(start_ready), 64'd1);
    check("rst.done_valid", 64'(done_valid), 64'd0);
    check("rst.result", 64'(result), 64'd0);
    check("rst.carry", 64'(carry_out), 64'd0);
    check("rst.ovf", 64'(overflow), 64'd0);
    #10 reset_n = 1'b1;
    tick();

    directed("add5p3", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    directed("addwrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("addovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    // 3 - 5 = -2, borrow so carry_out = 0
    directed("sub3m5", 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("subovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed("sub0m0", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    // done_ready while idle does nothing
    done_ready = 1'b1;
    tick(); tick();
    done_ready = 1'b0;
    check("idle_dr.start_ready", 64'(start_ready), 64'd1);
    check("idle_dr.done_valid", 64'(done_valid), 64'd0);

    // Stall in DONE with start_valid and operands toggling
    op_a = 32'h0000_0005; op_b = 32'h0000_0003; sub = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    lat = 1;
    while (!done_valid && lat < 200) begin tick(); lat++; end
    check("stall.latency", 64'(lat), 64'd33);
    for (int i = 0; i < 10; i++) begin
      start_valid = 1'($urandom_range(0, 1));
      op_a = $urandom; op_b = $urandom; sub = 1'($urandom_range(0, 1));
      tick();
      check("stall.result", 64'(result), 64'h8);
      check("stall.done_valid", 64'(done_valid), 64'd1);
      check("stall.start_ready", 64'(start_ready), 64'd0);
      check("stall.carry", 64'(carry_out), 64'd0);
      check("stall.ovf", 64'(overflow), 64'd0);
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check("stall.release_ready", 64'(start_ready), 64'd1);
    check("stall.release_valid", 64'(done_valid), 64'd0);

    // Abort with reset at RUN cycle 10
    op_a = 32'hAAAA_AAAA; op_b = 32'h5555_5555; sub = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    repeat (10) tick();
    check("abort.in_run", 64'(start_ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("abort.start_ready", 64'(start_ready), 64'd1);
    check("abort.done_valid", 64'(done_valid), 64'd0);
    check("abort.result", 64'(result), 64'd0);
    check("abort.carry", 64'(carry_out), 64'd0);
    check("abort.ovf", 64'(overflow), 64'd0);
    #1 reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done_valid) seen = 1'b1;
    end
    check("abort.no_done", 64'(seen), 64'd0);
    directed("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // Random operations against the arithmetic model
    for (int i = 0; i < 500; i++) begin
      logic [W-1:0] a, b;
      logic s;
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      if (i % 50 == 0) a = 32'h8000_0000;
      if (i % 50 == 1) b = 32'h7FFF_FFFF;
      exp = model(a, b, s);
      run_op(a, b, s, $urandom_range(0, 4), r, c, o, lat);
      check("rnd.result", 64'(r), 64'(exp[W-1:0]));
      check("rnd.carry", 64'(c), 64'(exp[W]));
      check("rnd.ovf", 64'(o), 64'(exp[W+1]));
      if (i % 100 == 0) check("rnd.latency", 64'(lat), 64'd33);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
